// File: rtl/freq_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : freq_sweep_ctrl
// Purpose  : Frequency sweep engine for a single-frequency synth core.
//            Steps freq from a start to a stop value. At each step it waits
//            a settle time, integrates 2**ACC_LOG2 I/Q samples, then
//            presents one {freq, I_sum, Q_sum} record on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module freq_sweep_ctrl #(
    parameter int FREQ_W     = 14,
    parameter int DATA_W     = 10,
    parameter int SETTLE_CYC = 64,
    parameter int ACC_LOG2   = 8,
    // Derived from DATA_W and ACC_LOG2; leave at its default.
    parameter int ACC_W      = DATA_W + ACC_LOG2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [FREQ_W-1:0]        f_start,
    input  logic [FREQ_W-1:0]        f_stop,
    input  logic [FREQ_W-1:0]        f_step,
    output logic [FREQ_W-1:0]        freq,
    input  logic                     sample_en,
    input  logic signed [DATA_W-1:0] I_in,
    input  logic signed [DATA_W-1:0] Q_in,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [FREQ_W-1:0]        res_freq,
    output logic signed [ACC_W-1:0]  res_i,
    output logic signed [ACC_W-1:0]  res_q,
    output logic                     busy,
    output logic                     done,
    output logic                     cfg_err
);

    // Settle counter is wide enough to reach SETTLE_CYC-1 (at least 1 bit).
    localparam int c_SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [c_SET_W-1:0] c_SET_LAST = c_SET_W'(SETTLE_CYC - 1);
    localparam logic [ACC_LOG2-1:0] c_SMP_LAST = {ACC_LOG2{1'b1}};

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_SETTLE = 3'd1;
    localparam logic [2:0] c_ACCUM  = 3'd2;
    localparam logic [2:0] c_OUTPUT = 3'd3;
    localparam logic [2:0] c_DONE   = 3'd4;

    logic [2:0]               r_state;
    logic [2:0]               w_state_nxt;
    logic [FREQ_W-1:0]        r_freq;
    logic [FREQ_W-1:0]        r_fstop;
    logic [FREQ_W-1:0]        r_fstep;
    logic [c_SET_W-1:0]       r_set_cnt;
    logic [ACC_LOG2-1:0]      r_smp_cnt;
    logic signed [ACC_W-1:0]  r_acc_i;
    logic signed [ACC_W-1:0]  r_acc_q;
    logic [FREQ_W-1:0]        r_res_freq;
    logic signed [ACC_W-1:0]  r_res_i;
    logic signed [ACC_W-1:0]  r_res_q;
    logic                     r_cfg_err;

    logic                     w_cfg_ok;
    logic                     w_last_set;
    logic                     w_last_smp;
    logic [FREQ_W:0]          w_next_freq;
    logic                     w_sweep_end;
    logic signed [ACC_W-1:0]  w_i_ext;
    logic signed [ACC_W-1:0]  w_q_ext;

    assign w_cfg_ok   = (f_step != '0) && (f_start <= f_stop);
    assign w_last_set = (r_set_cnt == c_SET_LAST);
    assign w_last_smp = (r_smp_cnt == c_SMP_LAST);
    // One extra bit so a step past the top of the freq range is detected
    // as the end of the sweep instead of wrapping.
    assign w_next_freq = {1'b0, r_freq} + {1'b0, r_fstep};
    assign w_sweep_end = (w_next_freq > {1'b0, r_fstop});
    assign w_i_ext     = {{ACC_LOG2{I_in[DATA_W-1]}}, I_in};
    assign w_q_ext     = {{ACC_LOG2{Q_in[DATA_W-1]}}, Q_in};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort overrides every other input in every state.
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start && w_cfg_ok) begin
                        w_state_nxt = c_SETTLE;
                    end
                end
                c_SETTLE: begin
                    if (w_last_set) begin
                        w_state_nxt = c_ACCUM;
                    end
                end
                c_ACCUM: begin
                    if (sample_en && w_last_smp) begin
                        w_state_nxt = c_OUTPUT;
                    end
                end
                c_OUTPUT: begin
                    if (res_ready) begin
                        w_state_nxt = w_sweep_end ? c_DONE : c_SETTLE;
                    end
                end
                c_DONE: begin
                    w_state_nxt = c_IDLE;
                end
                default: begin
                    w_state_nxt = c_IDLE;
                end
            endcase
        end
    end

    // Datapath: config latch, freq stepping, settle/sample counters,
    // accumulators and the result record. Counters and accumulators are
    // cleared on every edge that enters SETTLE. On abort everything holds,
    // so freq keeps its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_freq     <= '0;
            r_fstop    <= '0;
            r_fstep    <= '0;
            r_set_cnt  <= '0;
            r_smp_cnt  <= '0;
            r_acc_i    <= '0;
            r_acc_q    <= '0;
            r_res_freq <= '0;
            r_res_i    <= '0;
            r_res_q    <= '0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_cfg_err <= 1'b0;
            if (!abort) begin
                case (r_state)
                    c_IDLE: begin
                        if (start) begin
                            if (w_cfg_ok) begin
                                r_freq    <= f_start;
                                r_fstop   <= f_stop;
                                r_fstep   <= f_step;
                                r_set_cnt <= '0;
                                r_smp_cnt <= '0;
                                r_acc_i   <= '0;
                                r_acc_q   <= '0;
                            end else begin
                                r_cfg_err <= 1'b1;
                            end
                        end
                    end
                    c_SETTLE: begin
                        r_set_cnt <= r_set_cnt + c_SET_W'(1);
                    end
                    c_ACCUM: begin
                        if (sample_en) begin
                            r_smp_cnt <= r_smp_cnt + ACC_LOG2'(1);
                            if (w_last_smp) begin
                                // Final sample goes straight into the record.
                                r_res_freq <= r_freq;
                                r_res_i    <= r_acc_i + w_i_ext;
                                r_res_q    <= r_acc_q + w_q_ext;
                            end else begin
                                r_acc_i <= r_acc_i + w_i_ext;
                                r_acc_q <= r_acc_q + w_q_ext;
                            end
                        end
                    end
                    c_OUTPUT: begin
                        if (res_ready && !w_sweep_end) begin
                            r_freq    <= w_next_freq[FREQ_W-1:0];
                            r_set_cnt <= '0;
                            r_smp_cnt <= '0;
                            r_acc_i   <= '0;
                            r_acc_q   <= '0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign freq      = r_freq;
    assign res_valid = (r_state == c_OUTPUT);
    assign res_freq  = r_res_freq;
    assign res_i     = r_res_i;
    assign res_q     = r_res_q;
    assign busy      = (r_state != c_IDLE);
    assign done      = (r_state == c_DONE);
    assign cfg_err   = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_freq_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_freq_sweep_ctrl
// Purpose  : Self-checking bench for freq_sweep_ctrl. Sweeps from a vector
//            table plus random sweeps are logged cycle by cycle and checked
//            against a window/record model; abort and reset corner cases
//            are hand-written sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_freq_sweep_ctrl;

    localparam int FREQ_W     = 14;
    localparam int DATA_W     = 10;
    localparam int SETTLE_CYC = 64;
    localparam int ACC_LOG2   = 8;
    localparam int ACC_W      = DATA_W + ACC_LOG2;
    localparam int NWIN       = 1 << ACC_LOG2;
    localparam int MAXC       = 8000;
    localparam int NVEC       = 10;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start;
    logic                     abort;
    logic [FREQ_W-1:0]        f_start;
    logic [FREQ_W-1:0]        f_stop;
    logic [FREQ_W-1:0]        f_step;
    logic [FREQ_W-1:0]        freq;
    logic                     sample_en;
    logic signed [DATA_W-1:0] I_in;
    logic signed [DATA_W-1:0] Q_in;
    logic                     res_valid;
    logic                     res_ready;
    logic [FREQ_W-1:0]        res_freq;
    logic signed [ACC_W-1:0]  res_i;
    logic signed [ACC_W-1:0]  res_q;
    logic                     busy;
    logic                     done;
    logic                     cfg_err;

    always #5 clk = ~clk;

    freq_sweep_ctrl #(
        .FREQ_W    (FREQ_W),
        .DATA_W    (DATA_W),
        .SETTLE_CYC(SETTLE_CYC),
        .ACC_LOG2  (ACC_LOG2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .f_start  (f_start),
        .f_stop   (f_stop),
        .f_step   (f_step),
        .freq     (freq),
        .sample_en(sample_en),
        .I_in     (I_in),
        .Q_in     (Q_in),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_freq (res_freq),
        .res_i    (res_i),
        .res_q    (res_q),
        .busy     (busy),
        .done     (done),
        .cfg_err  (cfg_err)
    );

    // en_mode: 0 every cycle, 1 one in four, 2 random.
    // rdy_mode: 0 always ready, 1 stall 20 cycles per record, 2 random.
    typedef struct {
        int fs;
        int fe;
        int st;
        int en_mode;
        int rdy_mode;
        bit rnd_data;
        int i_val;
        int q_val;
        int exp_n;
        bit exp_err;
        int exp_i;
        int exp_q;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    vec_t vt[NVEC];

    // Per-cycle log: inputs sampled at edge n, outputs seen just after it.
    int lg_en[MAXC], lg_i[MAXC], lg_q[MAXC], lg_rdy[MAXC];
    int lg_valid[MAXC], lg_freq[MAXC], lg_rf[MAXC], lg_ri[MAXC], lg_rq[MAXC];
    int lg_busy[MAXC], lg_done[MAXC], lg_err[MAXC];
    int n;

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d at %0t", nm, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (n < MAXC) begin
            lg_en[n]    = int'(sample_en);
            lg_i[n]     = int'(I_in);
            lg_q[n]     = int'(Q_in);
            lg_rdy[n]   = int'(res_ready);
            lg_valid[n] = int'(res_valid);
            lg_freq[n]  = int'(freq);
            lg_rf[n]    = int'(res_freq);
            lg_ri[n]    = int'(res_i);
            lg_rq[n]    = int'(res_q);
            lg_busy[n]  = int'(busy);
            lg_done[n]  = int'(done);
            lg_err[n]   = int'(cfg_err);
            n++;
        end
    endtask

    task automatic drive_data(input vec_t v);
        case (v.en_mode)
            0:       sample_en = 1'b1;
            1:       sample_en = ((n % 4) == 0);
            default: sample_en = 1'($urandom_range(0, 1));
        endcase
        if (v.rnd_data) begin
            I_in = DATA_W'($urandom);
            Q_in = DATA_W'($urandom);
        end else begin
            I_in = DATA_W'(v.i_val);
            Q_in = DATA_W'(v.q_val);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int     scnt, b, f, k, cnt, L, a, nacc, ndone;
        longint isum, qsum;
        bit     fin, stop;
        n = 0;
        scnt = 0;
        f_start = FREQ_W'(v.fs);
        f_stop  = FREQ_W'(v.fe);
        f_step  = FREQ_W'(v.st);
        start = 1'b1;
        abort = 1'b0;
        res_ready = 1'b0;
        drive_data(v);
        tick();
        start = 1'b0;
        chk({tag, " cfg_err"}, lg_err[0], v.exp_err);
        if (v.exp_err) begin
            repeat (4) begin
                tick();
                chk({tag, " busy after cfg_err"}, lg_busy[n-1], 0);
                chk({tag, " cfg_err width"}, lg_err[n-1], 0);
                chk({tag, " valid after cfg_err"}, lg_valid[n-1], 0);
            end
            return;
        end
        // Drive until done; cfg inputs and start are scrambled mid-sweep.
        fin = 1'b0;
        while (!fin && n < MAXC - 2) begin
            f_start = FREQ_W'($urandom);
            f_stop  = FREQ_W'($urandom);
            f_step  = FREQ_W'($urandom);
            start   = ($urandom_range(0, 15) == 0);
            drive_data(v);
            case (v.rdy_mode)
                0: res_ready = 1'b1;
                1: begin
                    if (lg_valid[n-1] != 0) begin
                        res_ready = (scnt >= 20);
                        scnt = (scnt >= 20) ? 0 : scnt + 1;
                    end else begin
                        res_ready = 1'b0;
                    end
                end
                default: res_ready = 1'($urandom_range(0, 1));
            endcase
            tick();
            if (lg_done[n-1] != 0) fin = 1'b1;
        end
        start = 1'b0;
        tick();

        // Model: a step starts on the edge that enters it; after SETTLE_CYC
        // cycles the next NWIN strobes are summed; the record is valid from
        // the cycle after the last strobe until the first ready.
        b = 0;
        f = v.fs;
        stop = 1'b0;
        while (!stop) begin
            k = b + SETTLE_CYC;
            cnt = 0;
            isum = 0;
            qsum = 0;
            while (cnt < NWIN && k < n - 1) begin
                k++;
                if (lg_en[k] != 0) begin
                    isum += lg_i[k];
                    qsum += lg_q[k];
                    cnt++;
                end
            end
            if (cnt < NWIN) begin
                chk({tag, " window incomplete"}, cnt, NWIN);
                break;
            end
            L = k;
            a = L + 1;
            while (a < n && lg_rdy[a] == 0) a++;
            if (a >= n - 1) begin
                chk({tag, " no accept"}, a, n - 2);
                break;
            end
            for (int j = b; j < L; j++) begin
                chk({tag, " valid early"}, lg_valid[j], 0);
                chk({tag, " freq settle"}, lg_freq[j], f);
                chk({tag, " busy"}, lg_busy[j], 1);
            end
            for (int j = L; j < a; j++) begin
                chk({tag, " valid"}, lg_valid[j], 1);
                chk({tag, " res_freq"}, lg_rf[j], f);
                chk({tag, " res_i"}, lg_ri[j], isum);
                chk({tag, " res_q"}, lg_rq[j], qsum);
                chk({tag, " freq hold"}, lg_freq[j], f);
            end
            if (!v.rnd_data) begin
                chk({tag, " res_i value"}, lg_ri[L], v.exp_i);
                chk({tag, " res_q value"}, lg_rq[L], v.exp_q);
            end
            if (f + v.st > v.fe) begin
                chk({tag, " done pulse"}, lg_done[a], 1);
                chk({tag, " valid in done"}, lg_valid[a], 0);
                chk({tag, " freq at end"}, lg_freq[a], f);
                chk({tag, " busy after done"}, lg_busy[a+1], 0);
                stop = 1'b1;
            end else begin
                f = f + v.st;
                b = a;
            end
        end
        nacc = 0;
        ndone = 0;
        for (int j = 1; j < n; j++) begin
            if (lg_valid[j-1] != 0 && lg_rdy[j] != 0) nacc++;
            if (lg_done[j] != 0) ndone++;
        end
        chk({tag, " records"}, nacc, v.exp_n);
        chk({tag, " done count"}, ndone, 1);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int fs, st, fe, kk, c;
        vec_t va;
        n = 0;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        f_start = '0;
        f_stop = '0;
        f_step = '0;
        sample_en = 1'b0;
        I_in = '0;
        Q_in = '0;
        res_ready = 1'b0;

        vt[0] = '{10, 50, 10, 0, 0, 1'b0, 100, -50, 5, 1'b0, 25600, -12800};
        vt[1] = '{10, 50, 10, 0, 1, 1'b0, 100, -50, 5, 1'b0, 25600, -12800};
        vt[2] = '{10, 50, 0, 0, 0, 1'b0, 0, 0, 0, 1'b1, 0, 0};
        vt[3] = '{60, 50, 10, 0, 0, 1'b0, 0, 0, 0, 1'b1, 0, 0};
        vt[4] = '{16380, 16383, 10000, 0, 0, 1'b0, 3, 1, 1, 1'b0, 768, 256};
        vt[5] = '{100, 100, 1, 1, 0, 1'b0, -512, 511, 1, 1'b0, -131072, 130816};
        for (int i = 6; i < NVEC; i++) begin
            fs = $urandom_range(0, 16383);
            st = $urandom_range(1, 6000);
            kk = $urandom_range(0, 3);
            fe = fs + st * kk + $urandom_range(0, st - 1);
            if (fe > 16383) fe = 16383;
            vt[i] = '{fs, fe, st, 2, 2, 1'b1, 0, 0, (fe - fs) / st + 1, 1'b0, 0, 0};
        end

        // Reset state.
        tick();
        tick();
        chk("reset freq", lg_freq[1], 0);
        chk("reset res_valid", lg_valid[1], 0);
        chk("reset res_i", lg_ri[1], 0);
        chk("reset res_q", lg_rq[1], 0);
        chk("reset res_freq", lg_rf[1], 0);
        chk("reset busy", lg_busy[1], 0);
        chk("reset done", lg_done[1], 0);
        chk("reset cfg_err", lg_err[1], 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vt[i], $sformatf("vec%0d", i));
            repeat (3) tick();
        end

        // Abort in ACCUM, then a fresh sweep must start from clean sums.
        n = 0;
        sample_en = 1'b1;
        I_in = 100;
        Q_in = -50;
        res_ready = 1'b1;
        f_start = 10;
        f_stop = 50;
        f_step = 10;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (100) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort accum busy", lg_busy[n-1], 0);
        chk("abort accum valid", lg_valid[n-1], 0);
        chk("abort accum done", lg_done[n-1], 0);
        chk("abort accum freq kept", lg_freq[n-1], 10);
        repeat (5) begin
            tick();
            chk("abort accum no done", lg_done[n-1], 0);
        end
        va = '{200, 200, 5, 0, 0, 1'b0, 7, -3, 1, 1'b0, 1792, -768};
        run_vec(va, "after abort");

        // Abort while a record is stalled.
        n = 0;
        sample_en = 1'b1;
        I_in = 100;
        Q_in = -50;
        res_ready = 1'b0;
        f_start = 10;
        f_stop = 50;
        f_step = 10;
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        while (!res_valid && c < 400) begin
            tick();
            c++;
        end
        chk("stall reached valid", int'(res_valid), 1);
        repeat (5) tick();
        chk("stall valid held", lg_valid[n-1], 1);
        chk("stall res_i", lg_ri[n-1], 25600);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort output valid", lg_valid[n-1], 0);
        chk("abort output busy", lg_busy[n-1], 0);
        chk("abort output done", lg_done[n-1], 0);
        repeat (3) begin
            tick();
            chk("abort output no done", lg_done[n-1], 0);
        end

        // start and abort together: abort wins, no cfg_err either.
        start = 1'b1;
        abort = 1'b1;
        tick();
        chk("start+abort busy", lg_busy[n-1], 0);
        f_step = 0;
        tick();
        chk("start+abort bad cfg_err", lg_err[n-1], 0);
        start = 1'b0;
        abort = 1'b0;
        f_step = 10;
        tick();

        // Reset in the middle of the second step.
        n = 0;
        res_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (330) tick();
        chk("pre-rst busy", lg_busy[n-1], 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid rst freq", lg_freq[n-1], 0);
        chk("mid rst res_i", lg_ri[n-1], 0);
        chk("mid rst res_q", lg_rq[n-1], 0);
        chk("mid rst res_freq", lg_rf[n-1], 0);
        chk("mid rst busy", lg_busy[n-1], 0);
        chk("mid rst valid", lg_valid[n-1], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
